decode_queue: RTL and testbench

//  Multi-lane decode stage between fetch and rename. Each cycle it accepts a fetch packet of NR_LANES

---
 rtl/decode_queue_if.sv | 45 ++++
 rtl/decode_queue.sv | 182 ++++++++++++++++++
 tb/tb_decode_queue.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/decode_queue_if.sv
// -----------------------------------------------------------------------------
// Package C + decode_queue_if
//   C               : XLEN and the decoded-instruction record si_t shared by
//                     the decoder, the queue and the backend.
//   decode_queue_if : fetch-side packet handshake plus backend drain port.
//     in_valid_i / in_ready_o   fetch packet handshake
//     in_pc_i                   pc of lane 0 (lane k = in_pc_i + 4*k)
//     in_data_i / in_mask_i     NR_LANES instruction words and per-lane valid
//     out_valid_o               thermometer of available entries
//     out_si_o                  decoded entries head+k in slot k
//     out_cnt_i                 entries consumed by the backend this cycle
//   modport master : fetch/backend side, modport slave : decode_queue.
// -----------------------------------------------------------------------------
package C;
  localparam int XLEN = 32;

  typedef struct packed {
    logic            valid;   // 0 = illegal encoding, backend traps on it
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rd_we;
  } si_t;
endpackage

interface decode_queue_if #(parameter int NR_LANES = 2);
  localparam int OW = $clog2(NR_LANES + 1);

  logic                         in_valid_i;
  logic                         in_ready_o;
  logic [C::XLEN-1:0]           in_pc_i;
  logic [NR_LANES-1:0][31:0]    in_data_i;
  logic [NR_LANES-1:0]          in_mask_i;
  logic [NR_LANES-1:0]          out_valid_o;
  C::si_t [NR_LANES-1:0]        out_si_o;
  logic [OW-1:0]                out_cnt_i;

  modport master (output in_valid_i, in_pc_i, in_data_i, in_mask_i, out_cnt_i,
                  input  in_ready_o, out_valid_o, out_si_o);
  modport slave  (input  in_valid_i, in_pc_i, in_data_i, in_mask_i, out_cnt_i,
                  output in_ready_o, out_valid_o, out_si_o);
endinterface

// File: rtl/decode_queue.sv
// -----------------------------------------------------------------------------
// decode_queue
//   Multi-lane decode stage: decodes NR_LANES fetch words per cycle (one
//   static_decoder per lane), compacts the valid lanes in program order into a
//   DEPTH-entry circular queue and lets the backend drain up to NR_LANES
//   entries per cycle. An illegal lane is enqueued, later lanes are dropped and
//   input stays blocked until flush_i.
// Ports
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   flush_i         drop queue contents and any same-cycle input/dequeue
//   bus             decode_queue_if.slave (fetch handshake + drain port)
//   perf_dec_o      decoded-instruction counter
//   perf_ill_o      illegal-instruction counter
// Configuration
//   DECODE_QUEUE_PERF_EN : when defined the perf counters exist; otherwise both
//                          perf outputs are tied to 0.
// -----------------------------------------------------------------------------

// Minimal RV32 static decoder: legality by major opcode plus register fields.
module static_decoder (
  input  logic [31:0]        instr_i,
  input  logic [C::XLEN-1:0] pc_i,
  output C::si_t             si_o
);
  always_comb begin
    si_o        = '0;
    si_o.pc     = pc_i;
    si_o.instr  = instr_i;
    si_o.opcode = instr_i[6:0];
    si_o.rd     = instr_i[11:7];
    si_o.rs1    = instr_i[19:15];
    si_o.rs2    = instr_i[24:20];
    case (instr_i[6:0])
      7'h37, 7'h17, 7'h6f, 7'h67, 7'h03, 7'h13, 7'h33, 7'h73: begin
        si_o.valid = 1'b1;
        si_o.rd_we = (instr_i[11:7] != 5'd0);
      end
      7'h63, 7'h23, 7'h0f: si_o.valid = 1'b1;
      default: ;
    endcase
  end
endmodule

module decode_queue #(
  parameter int NR_LANES = 2,
  parameter int DEPTH    = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  decode_queue_if.slave       bus,
  output logic [31:0]         perf_dec_o,
  output logic [31:0]         perf_ill_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int XL = C::XLEN;

  logic [PW-1:0]         head_q, head_d, tail_q, tail_d, wptr;
  logic [CW-1:0]         count_q, count_d, n_enq, avail, deq;
  logic                  blocked_q, blocked_d;
  C::si_t                mem_q [DEPTH];
  C::si_t                mem_d [DEPTH];
  C::si_t [NR_LANES-1:0] dec_si;
  logic [NR_LANES-1:0]   keep;
  logic                  lane_stop, ill_hit, in_ready, accept;
  logic [NR_LANES-1:0]   out_valid;
  C::si_t [NR_LANES-1:0] out_si;

  for (genvar k = 0; k < NR_LANES; k++) begin : g_lane
    logic [XL-1:0] lane_pc;
    assign lane_pc = bus.in_pc_i + XL'(4 * k);
    static_decoder u_dec (.instr_i(bus.in_data_i[k]), .pc_i(lane_pc), .si_o(dec_si[k]));
  end

  // Ready looks only at registered state so the backend's out_cnt_i never
  // reaches in_ready_o combinationally.
  assign in_ready       = !flush_i && !blocked_q && (count_q <= CW'(DEPTH - NR_LANES));
  assign accept         = bus.in_valid_i && in_ready;
  assign bus.in_ready_o = in_ready;

  // Lane selection: masked lanes up to and including the first illegal one.
  always_comb begin
    keep      = '0;
    n_enq     = '0;
    lane_stop = 1'b0;
    ill_hit   = 1'b0;
    for (int k = 0; k < NR_LANES; k++) begin
      if (bus.in_mask_i[k] && !lane_stop) begin
        keep[k] = 1'b1;
        n_enq   = n_enq + CW'(1);
        if (!dec_si[k].valid) begin
          lane_stop = 1'b1;
          ill_hit   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    blocked_d = blocked_q;
    mem_d     = mem_q;
    wptr      = tail_q;
    // Over-large out_cnt_i is clamped to what is actually presented.
    avail = (count_q > CW'(NR_LANES)) ? CW'(NR_LANES) : count_q;
    deq   = (CW'(bus.out_cnt_i) > avail) ? avail : CW'(bus.out_cnt_i);
    if (flush_i) begin
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      blocked_d = 1'b0;
    end else begin
      if (accept) begin
        for (int k = 0; k < NR_LANES; k++) begin
          if (keep[k]) begin
            mem_d[wptr] = dec_si[k];
            wptr        = wptr + PW'(1);
          end
        end
      end
      tail_d    = wptr;
      blocked_d = blocked_q | (accept & ill_hit);
      head_d    = head_q + PW'(deq);
      count_d   = count_q + (accept ? n_enq : CW'(0)) - deq;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      blocked_q <= 1'b0;
      mem_q     <= '{default: '0};
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      blocked_q <= blocked_d;
      mem_q     <= mem_d;
    end
  end

  always_comb begin
    out_valid = '0;
    out_si    = '0;
    for (int k = 0; k < NR_LANES; k++) begin
      out_valid[k] = (count_q > CW'(k));
      out_si[k]    = mem_q[head_q + PW'(k)];
    end
  end
  assign bus.out_valid_o = out_valid;
  assign bus.out_si_o    = out_si;

`ifdef DECODE_QUEUE_PERF_EN
  logic [31:0] perf_dec_q, perf_dec_d, perf_ill_q, perf_ill_d;
  always_comb begin
    perf_dec_d = perf_dec_q + (accept ? 32'(n_enq) : 32'd0);
    perf_ill_d = perf_ill_q + 32'(accept & ill_hit);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_dec_q <= '0;
      perf_ill_q <= '0;
    end else begin
      perf_dec_q <= perf_dec_d;
      perf_ill_q <= perf_ill_d;
    end
  end
  assign perf_dec_o = perf_dec_q;
  assign perf_ill_o = perf_ill_q;
`else
  assign perf_dec_o = 32'd0;
  assign perf_ill_o = 32'd0;
`endif

  a_out_cnt_le_avail: assert property (@(posedge clk_i) disable iff (!rst_ni)
    CW'(bus.out_cnt_i) <= avail);
endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;
  localparam int NL = 2;
  localparam int DP = 8;
  localparam logic [31:0] ADDI = 32'h0010_0093;
  localparam logic [31:0] ADD  = 32'h0020_8133;
  localparam logic [31:0] LW   = 32'h0000_a183;
  localparam logic [31:0] ILL  = 32'h0000_0000;
`ifdef DECODE_QUEUE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] perf_dec, perf_ill;
  int          checks = 0;
  int          errors = 0;

  decode_queue_if #(.NR_LANES(NL)) bus ();
  decode_queue #(.NR_LANES(NL), .DEPTH(DP)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(bus.slave),
    .perf_dec_o(perf_dec), .perf_ill_o(perf_ill));

  always #5 clk = ~clk;

  typedef struct {
    logic        fl, vld;
    logic [31:0] pc, d0, d1;
    logic [1:0]  m, c;
    logic        e_rdy;
    logic [1:0]  e_ov;
    logic [31:0] e_p0, e_p1;
    logic [1:0]  e_sv;
  } vec_t;

  function automatic vec_t mk(input logic fl, vld, input logic [31:0] pc, d0, d1,
                              input logic [1:0] m, c, input logic rdy, input logic [1:0] ov,
                              input logic [31:0] p0, p1, input logic [1:0] sv);
    vec_t v;
    v.fl = fl; v.vld = vld; v.pc = pc; v.d0 = d0; v.d1 = d1; v.m = m; v.c = c;
    v.e_rdy = rdy; v.e_ov = ov; v.e_p0 = p0; v.e_p1 = p1; v.e_sv = sv;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fl, vld, input logic [31:0] pc, d0, d1,
                       input logic [1:0] m, c);
    flush          = fl;
    bus.in_valid_i = vld;
    bus.in_pc_i    = pc;
    bus.in_data_i[0] = d0;
    bus.in_data_i[1] = d1;
    bus.in_mask_i  = m;
    bus.out_cnt_i  = c;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  vec_t        vt [24];
  logic [31:0] mq [$];
  logic [31:0] pc, p1;
  logic [1:0]  m, c;
  logic        exp_rdy;
  int          sent, cyc;

  initial begin
    //        fl vld pc         d0    d1    m      c     rdy ov     p0         p1         sv
    vt[0]  = mk(0, 1, 32'h1000, ADDI, ADD,  2'b11, 2'd0, 1, 2'b11, 32'h1000, 32'h1004, 2'b11);
    vt[1]  = mk(0, 0, 32'h0,    0,    0,    2'b00, 2'd2, 1, 2'b00, 0,        0,        2'b00);
    vt[2]  = mk(0, 1, 32'h2000, ADD,  LW,   2'b10, 2'd0, 1, 2'b01, 32'h2004, 0,        2'b01);
    vt[3]  = mk(0, 0, 32'h0,    0,    0,    2'b00, 2'd1, 1, 2'b00, 0,        0,        2'b00);
    vt[4]  = mk(0, 1, 32'h3000, ADDI, ADD,  2'b11, 2'd0, 1, 2'b11, 32'h3000, 32'h3004, 2'b11);
    vt[5]  = mk(0, 1, 32'h3008, ADDI, ADD,  2'b11, 2'd0, 1, 2'b11, 32'h3000, 32'h3004, 2'b11);
    vt[6]  = mk(0, 1, 32'h3010, ADDI, ADD,  2'b11, 2'd0, 1, 2'b11, 32'h3000, 32'h3004, 2'b11);
    vt[7]  = mk(0, 1, 32'h3018, ADDI, ADD,  2'b11, 2'd0, 1, 2'b11, 32'h3000, 32'h3004, 2'b11);
    vt[8]  = mk(0, 1, 32'h4000, ADDI, ADD,  2'b11, 2'd2, 0, 2'b11, 32'h3008, 32'h300c, 2'b11);
    vt[9]  = mk(0, 0, 32'h0,    0,    0,    2'b00, 2'd0, 1, 2'b11, 32'h3008, 32'h300c, 2'b11);
    vt[10] = mk(0, 0, 32'h0,    0,    0,    2'b00, 2'd2, 1, 2'b11, 32'h3010, 32'h3014, 2'b11);
    vt[11] = mk(0, 0, 32'h0,    0,    0,    2'b00, 2'd2, 1, 2'b11, 32'h3018, 32'h301c, 2'b11);
    vt[12] = mk(0, 0, 32'h0,    0,    0,    2'b00, 2'd2, 1, 2'b00, 0,        0,        2'b00);
    vt[13] = mk(0, 1, 32'h5000, ILL,  ADDI, 2'b11, 2'd0, 1, 2'b01, 32'h5000, 0,        2'b00);
    vt[14] = mk(0, 1, 32'h6000, ADDI, ADD,  2'b11, 2'd0, 0, 2'b01, 32'h5000, 0,        2'b00);
    vt[15] = mk(0, 0, 32'h0,    0,    0,    2'b00, 2'd1, 0, 2'b00, 0,        0,        2'b00);
    vt[16] = mk(1, 0, 32'h0,    0,    0,    2'b00, 2'd0, 0, 2'b00, 0,        0,        2'b00);
    vt[17] = mk(0, 1, 32'h7000, ADDI, ADD,  2'b11, 2'd0, 1, 2'b11, 32'h7000, 32'h7004, 2'b11);
    vt[18] = mk(0, 1, 32'h7008, ADDI, ADD,  2'b11, 2'd0, 1, 2'b11, 32'h7000, 32'h7004, 2'b11);
    vt[19] = mk(0, 1, 32'h7010, ADDI, ADD,  2'b01, 2'd0, 1, 2'b11, 32'h7000, 32'h7004, 2'b11);
    vt[20] = mk(1, 1, 32'h8000, ADDI, ADD,  2'b11, 2'd2, 0, 2'b00, 0,        0,        2'b00);
    vt[21] = mk(0, 0, 32'h0,    0,    0,    2'b00, 2'd0, 1, 2'b00, 0,        0,        2'b00);
    vt[22] = mk(0, 1, 32'h9000, ADDI, LW,   2'b11, 2'd0, 1, 2'b11, 32'h9000, 32'h9004, 2'b11);
    vt[23] = mk(0, 0, 32'h0,    0,    0,    2'b00, 2'd2, 1, 2'b00, 0,        0,        2'b00);

    // Reset state
    drive(0, 0, 0, 0, 0, 2'b00, 2'd0);
    #1;
    chk("reset out_valid", 32'(bus.out_valid_o), 0);
    chk("reset in_ready", 32'(bus.in_ready_o), 1);
    chk("reset perf_dec", perf_dec, 0);
    chk("reset perf_ill", perf_ill, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 24; i++) begin
      drive(vt[i].fl, vt[i].vld, vt[i].pc, vt[i].d0, vt[i].d1, vt[i].m, vt[i].c);
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(bus.in_ready_o), 32'(vt[i].e_rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d out_valid", i), 32'(bus.out_valid_o), 32'(vt[i].e_ov));
      if (vt[i].e_ov[0]) begin
        chk($sformatf("v%0d slot0 pc", i), bus.out_si_o[0].pc, vt[i].e_p0);
        chk($sformatf("v%0d slot0 si.valid", i), 32'(bus.out_si_o[0].valid), 32'(vt[i].e_sv[0]));
      end
      if (vt[i].e_ov[1]) begin
        chk($sformatf("v%0d slot1 pc", i), bus.out_si_o[1].pc, vt[i].e_p1);
        chk($sformatf("v%0d slot1 si.valid", i), 32'(bus.out_si_o[1].valid), 32'(vt[i].e_sv[1]));
      end
      @(negedge clk);
    end
    chk("perf_dec after table", perf_dec, PERF ? 32'd19 : 32'd0);
    chk("perf_ill after table", perf_ill, PERF ? 32'd1 : 32'd0);

    // Wrap: 20 packets with 1/2 drains against an in-order pc queue model
    sent = 0;
    cyc  = 0;
    while ((sent < 20 || mq.size() > 0) && cyc < 300) begin
      pc = 32'h0000_a000 + 32'(8 * sent);
      case (sent % 5)
        0: m = 2'b11;
        1: m = 2'b01;
        2: m = 2'b10;
        3: m = 2'b11;
        default: m = 2'b00;
      endcase
      c = (cyc % 3 == 2) ? 2'd2 : 2'd1;
      if (int'(c) > mq.size()) c = 2'(mq.size());
      drive(0, sent < 20, pc, ADD, ADDI, m, c);
      #1;
      exp_rdy = (mq.size() <= DP - NL);
      chk("wrap in_ready", 32'(bus.in_ready_o), 32'(exp_rdy));
      chk("wrap out_valid", 32'(bus.out_valid_o),
          32'({mq.size() > 1, mq.size() > 0}));
      if (mq.size() > 0) chk("wrap slot0 pc", bus.out_si_o[0].pc, mq[0]);
      if (mq.size() > 1) chk("wrap slot1 pc", bus.out_si_o[1].pc, mq[1]);
      @(posedge clk);
      for (int j = 0; j < int'(c); j++) void'(mq.pop_front());
      if (sent < 20 && exp_rdy) begin
        if (m[0]) mq.push_back(pc);
        if (m[1]) begin p1 = pc + 32'd4; mq.push_back(p1); end
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("wrap packets sent", 32'(sent), 20);
    chk("wrap queue drained", 32'(mq.size()), 0);
    drive(0, 0, 0, 0, 0, 2'b00, 2'd0);
    #1;
    chk("wrap final out_valid", 32'(bus.out_valid_o), 0);
    chk("perf_dec after wrap", perf_dec, PERF ? 32'd43 : 32'd0);

    // Asynchronous reset mid-operation
    drive(0, 1, 32'hb000, ADDI, ADD, 2'b11, 2'd0);
    @(posedge clk); #1;
    chk("pre-reset out_valid", 32'(bus.out_valid_o), 3);
    drive(0, 0, 0, 0, 0, 2'b00, 2'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", 32'(bus.out_valid_o), 0);
    chk("async reset in_ready", 32'(bus.in_ready_o), 1);
    chk("async reset perf_dec", perf_dec, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset out_valid", 32'(bus.out_valid_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
